// File: rtl/ysyx_22041461_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22041461_pkg
// Shared definitions for the register file / scoreboard slice:
//   XLEN_DEF, NREG_DEF : default register width and register count
//   aw_of()            : address width derived from a register count
//   AW_DEF             : address width for the default register count
//   hazard_e           : reason the issue stage is being held back
// ----------------------------------------------------------------------------
package ysyx_22041461_pkg;

   localparam int XLEN_DEF = 64;
   localparam int NREG_DEF = 32;

   // Register counts are powers of two >= 2, so the address is exactly log2.
   function automatic int aw_of(input int nreg);
      return (nreg < 2) ? 1 : $clog2(nreg);
   endfunction

   localparam int AW_DEF = aw_of(NREG_DEF);

   typedef enum logic [1:0] {
      HZ_NONE  = 2'd0,
      HZ_RAW   = 2'd1,
      HZ_WAW   = 2'd2,
      HZ_FLUSH = 2'd3
   } hazard_e;

endpackage

// File: rtl/ysyx_22041461_scoreboard.sv
// ----------------------------------------------------------------------------
// ysyx_22041461_scoreboard
// Pending-write tracking and issue hazard detection.
//   clk, rst          : clock, asynchronous active-low reset
//   rs_addr, rs_en    : source operands of the issuing instruction
//   rs_bypass         : per-source flag, operand is forwarded from this
//                       cycle's writeback so it must not stall
//   iss_valid, iss_rd, iss_rd_en : issuing instruction
//   iss_ready         : issue may proceed this cycle
//   wb_valid, wb_addr : writeback that retires a pending write
//   flush             : drop every pending-write mark
//   busy              : pending-write bits, bit i = register i
// ----------------------------------------------------------------------------
module ysyx_22041461_scoreboard
   import ysyx_22041461_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int NRD  = 2,
   parameter int AW   = aw_of(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] rs_addr,
   input  logic [NRD-1:0]    rs_en,
   input  logic [NRD-1:0]    rs_bypass,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   input  logic              iss_rd_en,
   output logic              iss_ready,
   input  logic              wb_valid,
   input  logic [AW-1:0]     wb_addr,
   input  logic              flush,
   output logic [NREG-1:0]   busy
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NRD-1:0]  src_hz;
   logic            waw_hz;
   logic            fire;
   hazard_e         hazard;

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_src
         logic [AW-1:0] a;
         assign a          = rs_addr[gi*AW +: AW];
         assign src_hz[gi] = rs_en[gi] && (a != '0) && busy_q[a] && !rs_bypass[gi];
      end
   endgenerate

   // A writeback to the same destination in this cycle retires the older
   // write, so the new writer may take the mark over.
   always_comb begin
      waw_hz = iss_rd_en && (iss_rd != '0) && busy_q[iss_rd]
               && !(wb_valid && (wb_addr == iss_rd));
   end

   always_comb begin
      hazard = HZ_NONE;
      if (flush)
         hazard = HZ_FLUSH;
      else if (waw_hz)
         hazard = HZ_WAW;
      else if (|src_hz)
         hazard = HZ_RAW;
   end

   assign iss_ready = (hazard == HZ_NONE);
   assign fire      = iss_valid && iss_ready;

   // Order matters: clear from writeback first so that a same-cycle set of
   // the same register wins; flush overrides everything.
   always_comb begin
      busy_d = busy_q;
      if (wb_valid)
         busy_d[wb_addr] = 1'b0;
      if (fire && iss_rd_en && (iss_rd != '0))
         busy_d[iss_rd] = 1'b1;
      if (flush)
         busy_d = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/ysyx_22041461_rf_sb.sv
// ----------------------------------------------------------------------------
// ysyx_22041461_rf_sb
// Integer register file with a write-pending scoreboard for in-order issue.
//   clk, rst            : clock, asynchronous active-low reset
//   rs_addr, rs_en      : NRD read/source ports (port k at [k*AW +: AW])
//   rs_data             : combinational read data (port k at [k*XLEN +: XLEN])
//   iss_valid, iss_rd, iss_rd_en, iss_ready : issue handshake
//   wb_valid, wb_addr, wb_data              : writeback port
//   flush               : clear all pending-write marks
//   busy                : pending-write bits
// Optional feature: define YSYX_22041461_RF_BYPASS_EN to forward the
// writeback value onto matching read ports and release their stall in the
// writeback cycle. Without it reads return stored data only.
// Register 0 reads as zero and is never written or marked busy.
// ----------------------------------------------------------------------------
module ysyx_22041461_rf_sb
   import ysyx_22041461_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NRD*aw_of(NREG)-1:0] rs_addr,
   input  logic [NRD-1:0]          rs_en,
   output logic [NRD*XLEN-1:0]     rs_data,
   input  logic                    iss_valid,
   input  logic [aw_of(NREG)-1:0]  iss_rd,
   input  logic                    iss_rd_en,
   output logic                    iss_ready,
   input  logic                    wb_valid,
   input  logic [aw_of(NREG)-1:0]  wb_addr,
   input  logic [XLEN-1:0]         wb_data,
   input  logic                    flush,
   output logic [NREG-1:0]         busy
);

   localparam int AW = aw_of(NREG);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NRD-1:0]  rs_bypass;

   // Writeback is independent of the scoreboard: it lands even when the
   // target is not busy or a flush is in progress.
   always_comb begin
      regs_d = regs_q;
      if (wb_valid && (wb_addr != '0))
         regs_d[wb_addr] = wb_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         regs_q <= '{default: '0};
      else
         regs_q <= regs_d;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0]   a;
         logic [XLEN-1:0] stored;
         logic            hit;
         assign a      = rs_addr[gi*AW +: AW];
         assign stored = (a == '0) ? '0 : regs_q[a];
`ifdef YSYX_22041461_RF_BYPASS_EN
         assign hit    = wb_valid && (wb_addr == a) && (a != '0);
`else
         assign hit    = 1'b0;
`endif
         assign rs_bypass[gi]            = hit;
         assign rs_data[gi*XLEN +: XLEN] = hit ? wb_data : stored;
      end
   endgenerate

   ysyx_22041461_scoreboard #(
      .NREG (NREG),
      .NRD  (NRD),
      .AW   (AW)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .rs_addr   (rs_addr),
      .rs_en     (rs_en),
      .rs_bypass (rs_bypass),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_rd_en (iss_rd_en),
      .iss_ready (iss_ready),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .flush     (flush),
      .busy      (busy)
   );

endmodule

// File: tb/tb_ysyx_22041461_rf_sb.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041461_rf_sb
// Driver pushes the expected outputs for each cycle into a queue; a monitor
// samples the DUT a little after each falling edge and compares.
// A second small instance (NRD=3, NREG=16, XLEN=32) covers enable masking.
// ----------------------------------------------------------------------------
module tb_ysyx_22041461_rf_sb;

`ifdef YSYX_22041461_RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [9:0]   rs_addr = '0;
   logic [1:0]   rs_en = '0;
   logic [127:0] rs_data;
   logic         iss_valid = 1'b0;
   logic [4:0]   iss_rd = '0;
   logic         iss_rd_en = 1'b0;
   logic         iss_ready;
   logic         wb_valid = 1'b0;
   logic [4:0]   wb_addr = '0;
   logic [63:0]  wb_data = '0;
   logic         flush = 1'b0;
   logic [31:0]  busy;

   logic         rst2 = 1'b1;
   logic [11:0]  rs_addr2 = '0;
   logic [2:0]   rs_en2 = '0;
   logic [95:0]  rs_data2;
   logic         iss_valid2 = 1'b0;
   logic [3:0]   iss_rd2 = '0;
   logic         iss_rd_en2 = 1'b0;
   logic         iss_ready2;
   logic         wb_valid2 = 1'b0;
   logic [3:0]   wb_addr2 = '0;
   logic [31:0]  wb_data2 = '0;
   logic         flush2 = 1'b0;
   logic [15:0]  busy2;

   always #5 clk = ~clk;

   ysyx_22041461_rf_sb dut (
      .clk(clk), .rst(rst_n), .rs_addr(rs_addr), .rs_en(rs_en), .rs_data(rs_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rd_en(iss_rd_en), .iss_ready(iss_ready),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .busy(busy)
   );

   ysyx_22041461_rf_sb #(.XLEN(32), .NREG(16), .NRD(3)) dut2 (
      .clk(clk), .rst(rst2), .rs_addr(rs_addr2), .rs_en(rs_en2), .rs_data(rs_data2),
      .iss_valid(iss_valid2), .iss_rd(iss_rd2), .iss_rd_en(iss_rd_en2), .iss_ready(iss_ready2),
      .wb_valid(wb_valid2), .wb_addr(wb_addr2), .wb_data(wb_data2), .flush(flush2), .busy(busy2)
   );

   typedef struct {
      bit        rst_n;
      bit        iss_valid;
      bit [4:0]  iss_rd;
      bit        iss_rd_en;
      bit [4:0]  rs_a0;
      bit [4:0]  rs_a1;
      bit [1:0]  rs_en;
      bit        wb_valid;
      bit [4:0]  wb_addr;
      bit [63:0] wb_data;
      bit        flush;
   } stim_t;

   typedef struct {
      int        id;
      bit        ready;
      bit [31:0] busy;
      bit [63:0] d0;
      bit [63:0] d1;
   } exp_t;

   exp_t      exp_q[$];
   exp_t      mon_e;
   int        n_checks = 0;
   int        n_err = 0;
   int        txn_id = 0;

   // Reference model: the architectural register values and the set of
   // registers with an outstanding write.
   bit [63:0] ref_regs [32];
   bit        ref_pend [32];

   task automatic chk(input string name, input int id, input logic [63:0] act,
                      input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s txn=%0d actual=%h required=%h", name, id, act, req);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      s.rst_n = 1'b1;
      return s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         ref_regs[i] = '0;
         ref_pend[i] = 1'b0;
      end
   endtask

   task automatic cycle(input stim_t s);
      exp_t      e;
      bit        raw;
      bit        waw;
      bit        hit;
      bit [4:0]  a;
      bit [63:0] d;
      @(negedge clk);
      rst_n     = s.rst_n;
      iss_valid = s.iss_valid;
      iss_rd    = s.iss_rd;
      iss_rd_en = s.iss_rd_en;
      rs_addr   = {s.rs_a1, s.rs_a0};
      rs_en     = s.rs_en;
      wb_valid  = s.wb_valid;
      wb_addr   = s.wb_addr;
      wb_data   = s.wb_data;
      flush     = s.flush;
      if (!s.rst_n)
         model_reset();
      raw = 1'b0;
      for (int k = 0; k < 2; k++) begin
         a   = (k == 0) ? s.rs_a0 : s.rs_a1;
         hit = BYP && s.wb_valid && (s.wb_addr == a) && (a != 0);
         d   = hit ? s.wb_data : ((a == 0) ? 64'd0 : ref_regs[a]);
         if (s.rs_en[k] && (a != 0) && ref_pend[a] && !hit)
            raw = 1'b1;
         if (k == 0) e.d0 = d; else e.d1 = d;
      end
      waw = s.iss_rd_en && (s.iss_rd != 0) && ref_pend[s.iss_rd]
            && !(s.wb_valid && s.wb_addr == s.iss_rd);
      e.ready = !raw && !waw && !s.flush;
      for (int i = 0; i < 32; i++)
         e.busy[i] = ref_pend[i];
      e.id = txn_id;
      txn_id++;
      exp_q.push_back(e);
      @(posedge clk);
      if (s.rst_n) begin
         if (s.wb_valid && s.wb_addr != 0)
            ref_regs[s.wb_addr] = s.wb_data;
         if (s.wb_valid)
            ref_pend[s.wb_addr] = 1'b0;
         if (s.iss_valid && e.ready && s.iss_rd_en && s.iss_rd != 0)
            ref_pend[s.iss_rd] = 1'b1;
         if (s.flush)
            for (int i = 0; i < 32; i++) ref_pend[i] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("iss_ready", mon_e.id, {63'd0, iss_ready}, {63'd0, mon_e.ready});
         chk("busy", mon_e.id, {32'd0, busy}, {32'd0, mon_e.busy});
         chk("rs_data0", mon_e.id, rs_data[63:0], mon_e.d0);
         chk("rs_data1", mon_e.id, rs_data[127:64], mon_e.d1);
         $display("txn %0d ready=%0b busy=%h d0=%h d1=%h", mon_e.id, iss_ready, busy,
                  rs_data[63:0], rs_data[127:64]);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog txn=%0d actual=timeout required=finish", txn_id);
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_t s;
      model_reset();

      // Reset asserted between edges, then released.
      s = idle(); s.rst_n = 1'b0; cycle(s);
      s = idle(); cycle(s);

      // Issue rd=5, dependent read stalls, writeback releases it.
      s = idle(); s.iss_valid = 1; s.iss_rd = 5; s.iss_rd_en = 1; cycle(s);
      s = idle(); s.iss_valid = 1; s.rs_a0 = 5; s.rs_en = 2'b01; cycle(s);
      s.wb_valid = 1; s.wb_addr = 5; s.wb_data = 64'hDEAD; cycle(s);
      s = idle(); s.iss_valid = 1; s.rs_a0 = 5; s.rs_en = 2'b01; cycle(s);

      // Set wins over same-cycle clear, then WAW.
      s = idle(); s.flush = 1; cycle(s);
      s = idle(); s.iss_valid = 1; s.iss_rd = 7; s.iss_rd_en = 1;
      s.wb_valid = 1; s.wb_addr = 7; s.wb_data = 64'h77; cycle(s);
      s = idle(); s.iss_valid = 1; s.iss_rd = 7; s.iss_rd_en = 1; cycle(s);

      // Register 0 is never written nor marked busy.
      s = idle(); s.wb_valid = 1; s.wb_addr = 0; s.wb_data = 64'hFFFF; cycle(s);
      s = idle(); s.iss_valid = 1; s.iss_rd = 0; s.iss_rd_en = 1; s.rs_en = 2'b11; cycle(s);
      s = idle(); cycle(s);

      // Flush with a concurrent writeback.
      s = idle(); s.flush = 1; cycle(s);
      s = idle(); s.iss_valid = 1; s.iss_rd_en = 1; s.iss_rd = 3; cycle(s);
      s.iss_rd = 9; cycle(s);
      s.iss_rd = 31; cycle(s);
      s = idle(); s.flush = 1; s.iss_valid = 1; s.wb_valid = 1; s.wb_addr = 9;
      s.wb_data = 64'h42; cycle(s);
      s = idle(); s.rs_a0 = 9; s.rs_a1 = 31; s.rs_en = 2'b11; s.iss_valid = 1; cycle(s);

      // Random traffic, concentrated on a few registers to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         s = idle();
         s.iss_valid = 1'($urandom_range(0, 1));
         s.iss_rd    = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                                   : 5'($urandom_range(0, 7));
         s.iss_rd_en = ($urandom_range(0, 3) != 0);
         s.rs_a0     = 5'($urandom_range(0, 7));
         s.rs_a1     = 5'($urandom_range(0, 7));
         s.rs_en     = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) < 4) begin
            s.wb_valid = 1'b1;
            s.wb_addr  = 5'($urandom_range(0, 7));
            s.wb_data  = {$urandom, $urandom};
         end
         s.flush = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 99) == 0)
            s.rst_n = 1'b0;
         cycle(s);
      end
      s = idle(); cycle(s);

      // Drain, bounded.
      for (int i = 0; i < 5 && exp_q.size() != 0; i++)
         @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_err++;
         $display("FAIL drain txn=%0d actual=%0d pending required=0", txn_id, exp_q.size());
      end

      // Narrow build: only enabled sources can stall.
      @(negedge clk);
      rst2 = 1'b0;
      #2;
      chk("dut2_reset_busy", -1, {48'd0, busy2}, 64'd0);
      chk("dut2_reset_ready", -1, {63'd0, iss_ready2}, 64'd1);
      @(negedge clk);
      rst2 = 1'b1; iss_valid2 = 1'b1; iss_rd2 = 4'd4; iss_rd_en2 = 1'b1;
      #2;
      chk("dut2_issue_ready", -1, {63'd0, iss_ready2}, 64'd1);
      @(negedge clk);
      iss_valid2 = 1'b1; iss_rd_en2 = 1'b0; iss_rd2 = 4'd0;
      rs_addr2 = {4'd1, 4'd2, 4'd4}; rs_en2 = 3'b010;
      #2;
      chk("dut2_busy", -1, {48'd0, busy2}, 64'h10);
      chk("dut2_masked_ready", -1, {63'd0, iss_ready2}, 64'd1);
      rs_en2 = 3'b001;
      #1;
      chk("dut2_raw_ready", -1, {63'd0, iss_ready2}, 64'd0);
      iss_valid2 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
